unidade_controle: RTL and testbench
===================================

UNIDADE_CONTROLE -- requirements
Module: unidade_controle

Interface
REQ-001 Parameters: none; the state encoding is fixed by REQ-017.
REQ-002 clock  input  1  single system clock; all state updates occur on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 forces the reset state immediately.
REQ-004 iniciar  input  1  start or restart request, level-sampled.
REQ-005 tem_jogada  input  1  one-cycle button pulse from the edge detector.
REQ-006 escolhe_macro  input  1  the addressed macro cell is finished, so the player chooses a macro freely.
REQ-007 jogada_valida  input  1  the selected micro cell is empty.
REQ-008 fim_jogo  input  1  the game has ended (win or draw).
REQ-009 zeraEdge, zeraR_micro, zeraR_macro  output  1 each  clears for the edge detector and the micro/macro registers.
REQ-010 registraR_micro, registraR_macro  output  1 each  load enables for the micro and macro registers.
REQ-011 sinal_macro  output  1  macro mux select: 1 selects the buttons, 0 selects the micro register.
REQ-012 escreve_tabuleiro  output  1  board-state RAM write enable.
REQ-013 jogador  output  1  current player: 0 = X, 1 = O.
REQ-014 pronto  output  1  game finished.
REQ-015 db_estado  output  4  current state code, for debug.

Function
REQ-016 Moore FSM; every output other than jogador is decoded from the registered state only.
REQ-017 States and codes:
- inicial=0, preparacao=1, espera_macro=2, registra_macro=3, espera_jogada=4, registra_jogada=5
- valida_jogada=6, escreve=7, verifica_fim=8, troca_jogador=9, atualiza_macro=A, checa_macro=B, fim=C
- codes D–F are illegal and SHALL return to inicial on the next edge.
REQ-018 inicial: all strobes are 0; iniciar=1 -> preparacao; otherwise stay.
REQ-019 preparacao: zeraEdge=zeraR_micro=zeraR_macro=1 for one cycle; jogador<=0; -> espera_macro.
REQ-020 espera_macro: sinal_macro=1; tem_jogada=1 -> registra_macro; otherwise stay.
REQ-021 registra_macro: sinal_macro=1 and registraR_macro=1; -> espera_jogada.
REQ-022 espera_jogada: tem_jogada=1 -> registra_jogada; otherwise stay.
REQ-023 registra_jogada: registraR_micro=1; -> valida_jogada.
REQ-024 valida_jogada: jogada_valida=1 -> escreve; otherwise -> espera_jogada; the rejected move is discarded and jogador is unchanged.
REQ-025 escreve: escreve_tabuleiro=1 for exactly one cycle; -> verifica_fim.
REQ-026 verifica_fim: fim_jogo=1 -> fim; otherwise -> troca_jogador.
REQ-027 troca_jogador: jogador toggles on exit; -> atualiza_macro.
REQ-028 atualiza_macro: sinal_macro=0 and registraR_macro=1 (macro <= micro); -> checa_macro.
REQ-029 checa_macro: escolhe_macro=1 -> espera_macro; otherwise -> espera_jogada.
REQ-030 fim: pronto=1; iniciar=1 -> preparacao (restart); otherwise stay.
REQ-031 tem_jogada pulses arriving in any state other than espera_macro or espera_jogada SHALL be ignored, not queued.
REQ-032 iniciar SHALL have no effect outside inicial and fim; a game cannot be restarted while it is in progress.
REQ-033 Latency: a valid move written in state escreve is written 3 cycles after the tem_jogada pulse is sampled (espera_jogada -> registra_jogada -> valida_jogada -> escreve).
REQ-034 At most one of registraR_micro and registraR_macro is asserted in any cycle.
REQ-035 escreve_tabuleiro is never asserted in the same cycle as any zera* signal.

Reset
REQ-036 reset=0 asynchronously forces state=inicial, jogador=0, and every strobe, pronto and sinal_macro to 0, with db_estado=0.
REQ-037 Reset asserted mid-game (any state) SHALL abandon the game with no further RAM write.
REQ-038 On reset release, the FSM advances only from the next rising clock edge.

Verification
REQ-039 Reset then iniciar=1 -> one cycle with all three zera* signals =1, then db_estado=2 and sinal_macro=1.
REQ-040 Full valid move with escolhe_macro=0 -> states 2,3,4,5,6,7,8,9,A,B,4 in order; jogador goes from 0 to 1; escreve_tabuleiro pulses exactly once.
REQ-041 Move with jogada_valida=0 -> state 6 then 4; no escreve_tabuleiro; jogador stays 0.
REQ-042 fim_jogo=1 in verifica_fim -> db_estado=C and pronto=1 held; a later iniciar=1 -> preparacao with jogador reset to 0.
REQ-043 tem_jogada pulsed in states 3, 5 and 7 -> ignored, no extra register loads; reset=0 pulsed in state 7 -> db_estado=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/unidade_controle_if.sv
// Handshake bundle between the game datapath/buttons and the control unit.
//   Datapath -> control : iniciar, tem_jogada, escolhe_macro, jogada_valida, fim_jogo
//   Control -> datapath : zeraEdge, zeraR_micro, zeraR_macro, registraR_micro,
//                         registraR_macro, sinal_macro, escreve_tabuleiro,
//                         jogador, pronto, db_estado[3:0]
// The control unit connects through modport slave; the datapath (or a bench)
// drives through modport master.
interface unidade_controle_if;
  logic       iniciar;
  logic       tem_jogada;
  logic       escolhe_macro;
  logic       jogada_valida;
  logic       fim_jogo;
  logic       zeraEdge;
  logic       zeraR_micro;
  logic       zeraR_macro;
  logic       registraR_micro;
  logic       registraR_macro;
  logic       sinal_macro;
  logic       escreve_tabuleiro;
  logic       jogador;
  logic       pronto;
  logic [3:0] db_estado;

  modport slave (
    input  iniciar, tem_jogada, escolhe_macro, jogada_valida, fim_jogo,
    output zeraEdge, zeraR_micro, zeraR_macro, registraR_micro, registraR_macro,
           sinal_macro, escreve_tabuleiro, jogador, pronto, db_estado
  );

  modport master (
    output iniciar, tem_jogada, escolhe_macro, jogada_valida, fim_jogo,
    input  zeraEdge, zeraR_micro, zeraR_macro, registraR_micro, registraR_macro,
           sinal_macro, escreve_tabuleiro, jogador, pronto, db_estado
  );
endinterface

// File: rtl/unidade_controle.sv
// Control unit of the ultimate tic-tac-toe game: a Moore FSM that sequences
// macro-cell selection, micro-cell selection, move validation, board write,
// end-of-game check and player swap.
// Ports:
//   clock  - system clock, rising edge active
//   reset  - asynchronous, active-low reset
//   bus    - unidade_controle_if.slave (game inputs, strobes, jogador,
//            pronto, db_estado)
// Strobe outputs are registered: each is loaded with the decode of the next
// state, so it always equals the decode of the current registered state.
module unidade_controle (
  input  logic                     clock,
  input  logic                     reset,
  unidade_controle_if.slave        bus
);

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    ESPERA_MACRO   = 4'h2,
    REGISTRA_MACRO = 4'h3,
    ESPERA_JOGADA  = 4'h4,
    REGISTRA_JOG   = 4'h5,
    VALIDA_JOGADA  = 4'h6,
    ESCREVE        = 4'h7,
    VERIFICA_FIM   = 4'h8,
    TROCA_JOGADOR  = 4'h9,
    ATUALIZA_MACRO = 4'hA,
    CHECA_MACRO    = 4'hB,
    FIM            = 4'hC
  } estado_t;

  typedef struct packed {
    logic zera_edge;
    logic zera_micro;
    logic zera_macro;
    logic reg_micro;
    logic reg_macro;
    logic sinal_macro;
    logic escreve;
    logic pronto;
  } saidas_t;

  estado_t state_q, state_d;
  saidas_t saidas_q, saidas_d;
  logic    jogador_q, jogador_d;

  // Moore output decode; unlisted and illegal codes drive every strobe low.
  function automatic saidas_t decodifica(input estado_t st);
    saidas_t s;
    s = '0;
    case (st)
      PREPARACAO: begin
        s.zera_edge  = 1'b1;
        s.zera_micro = 1'b1;
        s.zera_macro = 1'b1;
      end
      ESPERA_MACRO:   s.sinal_macro = 1'b1;
      REGISTRA_MACRO: begin
        s.sinal_macro = 1'b1;
        s.reg_macro   = 1'b1;
      end
      REGISTRA_JOG:   s.reg_micro = 1'b1;
      ESCREVE:        s.escreve   = 1'b1;
      // sinal_macro stays 0 so the macro register reloads from the micro register
      ATUALIZA_MACRO: s.reg_macro = 1'b1;
      FIM:            s.pronto    = 1'b1;
      default:        s = '0;
    endcase
    return s;
  endfunction

  // Next-state logic; tem_jogada and iniciar are only looked at in the waiting states.
  always_comb begin
    state_d = state_q;
    case (state_q)
      INICIAL: begin
        if (bus.iniciar) state_d = PREPARACAO;
        else             state_d = INICIAL;
      end
      PREPARACAO: state_d = ESPERA_MACRO;
      ESPERA_MACRO: begin
        if (bus.tem_jogada) state_d = REGISTRA_MACRO;
        else                state_d = ESPERA_MACRO;
      end
      REGISTRA_MACRO: state_d = ESPERA_JOGADA;
      ESPERA_JOGADA: begin
        if (bus.tem_jogada) state_d = REGISTRA_JOG;
        else                state_d = ESPERA_JOGADA;
      end
      REGISTRA_JOG: state_d = VALIDA_JOGADA;
      VALIDA_JOGADA: begin
        if (bus.jogada_valida) state_d = ESCREVE;
        else                   state_d = ESPERA_JOGADA;
      end
      ESCREVE: state_d = VERIFICA_FIM;
      VERIFICA_FIM: begin
        if (bus.fim_jogo) state_d = FIM;
        else              state_d = TROCA_JOGADOR;
      end
      TROCA_JOGADOR:  state_d = ATUALIZA_MACRO;
      ATUALIZA_MACRO: state_d = CHECA_MACRO;
      CHECA_MACRO: begin
        if (bus.escolhe_macro) state_d = ESPERA_MACRO;
        else                   state_d = ESPERA_JOGADA;
      end
      FIM: begin
        if (bus.iniciar) state_d = PREPARACAO;
        else             state_d = FIM;
      end
      default: state_d = INICIAL;
    endcase
  end

  // Current-player next value: cleared while preparing, toggled when leaving troca_jogador.
  always_comb begin
    jogador_d = jogador_q;
    case (state_q)
      PREPARACAO:    jogador_d = 1'b0;
      TROCA_JOGADOR: jogador_d = ~jogador_q;
      default:       jogador_d = jogador_q;
    endcase
  end

  // Registered strobes track the state that is being entered.
  always_comb begin
    saidas_d = decodifica(state_d);
  end

  // State, player and strobe registers with asynchronous reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= INICIAL;
      jogador_q <= 1'b0;
      saidas_q  <= '0;
    end else begin
      state_q   <= state_d;
      jogador_q <= jogador_d;
      saidas_q  <= saidas_d;
    end
  end

  assign bus.zeraEdge          = saidas_q.zera_edge;
  assign bus.zeraR_micro       = saidas_q.zera_micro;
  assign bus.zeraR_macro       = saidas_q.zera_macro;
  assign bus.registraR_micro   = saidas_q.reg_micro;
  assign bus.registraR_macro   = saidas_q.reg_macro;
  assign bus.sinal_macro       = saidas_q.sinal_macro;
  assign bus.escreve_tabuleiro = saidas_q.escreve;
  assign bus.pronto            = saidas_q.pronto;
  assign bus.jogador           = jogador_q;
  assign bus.db_estado         = state_q;

endmodule

// File: tb/tb_unidade_controle.sv
// Directed bench for unidade_controle: walks full games through the FSM and
// compares every observed output against hand-computed values.
module tb_unidade_controle;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  int   n_escreve;
  int   exp_escreve;
  logic exp_jog;

  unidade_controle_if bus ();

  unidade_controle dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Counts board-write cycles seen at each rising edge.
  always @(posedge clock) begin
    if (bus.escreve_tabuleiro === 1'b1) n_escreve <= n_escreve + 1;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; sample 1 ns after the edge, then check the cross-strobe rules.
  task automatic step();
    @(posedge clock);
    #1;
    chk("reg_excl", {7'd0, bus.registraR_micro & bus.registraR_macro}, 8'd0);
    chk("esc_zera", {7'd0, bus.escreve_tabuleiro &
                     (bus.zeraEdge | bus.zeraR_micro | bus.zeraR_macro)}, 8'd0);
  endtask

  // One move. from_macro: start in espera_macro; valid/esc/fim drive the datapath flags.
  task automatic jogada(input logic from_macro, input logic valid,
                        input logic esc, input logic fim);
    if (from_macro) begin
      chk("start_macro", {4'd0, bus.db_estado}, 8'h02);
      bus.tem_jogada = 1'b1;
      step();
      bus.tem_jogada = 1'b1;  // held into registra_macro: must be ignored
      chk("st_reg_macro", {4'd0, bus.db_estado}, 8'h03);
      chk("ld_macro", {6'd0, bus.sinal_macro, bus.registraR_macro}, 8'h03);
      step();
      bus.tem_jogada = 1'b0;
      chk("st_esp_jog_a", {4'd0, bus.db_estado}, 8'h04);
      chk("no_ld_a", {6'd0, bus.registraR_micro, bus.registraR_macro}, 8'h00);
    end
    step();
    chk("st_esp_jog_b", {4'd0, bus.db_estado}, 8'h04);
    bus.tem_jogada = 1'b1;
    step();
    chk("st_reg_jog", {4'd0, bus.db_estado}, 8'h05);
    chk("ld_micro", {6'd0, bus.registraR_micro, bus.registraR_macro}, 8'h02);
    bus.jogada_valida = valid;
    bus.tem_jogada    = 1'b1;  // pulse in registra_jogada: ignored
    step();
    bus.tem_jogada = 1'b0;
    chk("st_valida", {4'd0, bus.db_estado}, 8'h06);
    chk("no_ld_b", {6'd0, bus.registraR_micro, bus.registraR_macro}, 8'h00);
    step();
    if (!valid) begin
      chk("st_rejeita", {4'd0, bus.db_estado}, 8'h04);
      chk("no_escreve", {7'd0, bus.escreve_tabuleiro}, 8'h00);
      chk("jog_rejeita", {7'd0, bus.jogador}, {7'd0, exp_jog});
      chk("cnt_rejeita", n_escreve[7:0], exp_escreve[7:0]);
    end else begin
      chk("st_escreve", {4'd0, bus.db_estado}, 8'h07);
      chk("escreve_on", {7'd0, bus.escreve_tabuleiro}, 8'h01);
      bus.tem_jogada = 1'b1;  // pulse in escreve: ignored
      bus.fim_jogo   = fim;
      step();
      bus.tem_jogada = 1'b0;
      exp_escreve++;
      chk("st_verifica", {4'd0, bus.db_estado}, 8'h08);
      chk("escreve_off", {7'd0, bus.escreve_tabuleiro}, 8'h00);
      chk("cnt_escreve", n_escreve[7:0], exp_escreve[7:0]);
      step();
      if (fim) begin
        chk("st_fim", {4'd0, bus.db_estado}, 8'h0C);
        chk("pronto_on", {7'd0, bus.pronto}, 8'h01);
        chk("jog_fim", {7'd0, bus.jogador}, {7'd0, exp_jog});
      end else begin
        chk("st_troca", {4'd0, bus.db_estado}, 8'h09);
        chk("jog_antes", {7'd0, bus.jogador}, {7'd0, exp_jog});
        exp_jog = ~exp_jog;
        step();
        chk("st_atualiza", {4'd0, bus.db_estado}, 8'h0A);
        chk("ld_mac_micro", {6'd0, bus.sinal_macro, bus.registraR_macro}, 8'h01);
        chk("jog_depois", {7'd0, bus.jogador}, {7'd0, exp_jog});
        bus.escolhe_macro = esc;
        step();
        chk("st_checa", {4'd0, bus.db_estado}, 8'h0B);
        step();
        bus.escolhe_macro = 1'b0;
        chk("st_proximo", {4'd0, bus.db_estado}, esc ? 8'h02 : 8'h04);
      end
    end
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    n_escreve         = 0;
    exp_escreve       = 0;
    exp_jog           = 1'b0;
    bus.iniciar       = 1'b0;
    bus.tem_jogada    = 1'b0;
    bus.escolhe_macro = 1'b0;
    bus.jogada_valida = 1'b0;
    bus.fim_jogo      = 1'b0;
    reset             = 1'b0;
    #2;
    chk("rst_estado", {4'd0, bus.db_estado}, 8'h00);
    chk("rst_saidas", {bus.zeraEdge, bus.zeraR_micro, bus.zeraR_macro, bus.registraR_micro,
                       bus.registraR_macro, bus.sinal_macro, bus.escreve_tabuleiro,
                       bus.pronto}, 8'h00);
    chk("rst_jog", {7'd0, bus.jogador}, 8'h00);

    @(negedge clock);
    reset = 1'b1;
    step();
    chk("idle_inicial", {4'd0, bus.db_estado}, 8'h00);
    bus.iniciar = 1'b1;
    step();
    bus.iniciar = 1'b0;
    chk("st_prep", {4'd0, bus.db_estado}, 8'h01);
    chk("zera_on", {5'd0, bus.zeraEdge, bus.zeraR_micro, bus.zeraR_macro}, 8'h07);
    step();
    chk("st_esp_macro", {4'd0, bus.db_estado}, 8'h02);
    chk("zera_off", {5'd0, bus.zeraEdge, bus.zeraR_micro, bus.zeraR_macro}, 8'h00);
    chk("sinal_macro", {7'd0, bus.sinal_macro}, 8'h01);

    // valid move, escolhe_macro=0: 2..B then 4, X -> O
    jogada(1'b1, 1'b1, 1'b0, 1'b0);
    // iniciar mid-game has no effect
    bus.iniciar = 1'b1;
    step();
    bus.iniciar = 1'b0;
    chk("iniciar_ign", {4'd0, bus.db_estado}, 8'h04);
    // rejected move: jogador stays O
    jogada(1'b0, 1'b0, 1'b0, 1'b0);
    // valid move, free macro choice next: back to espera_macro, O -> X
    jogada(1'b0, 1'b1, 1'b1, 1'b0);
    // valid move from macro choice: X -> O
    jogada(1'b1, 1'b1, 1'b0, 1'b0);
    // winning move: fim with O still current
    jogada(1'b0, 1'b1, 1'b0, 1'b1);
    bus.fim_jogo = 1'b0;
    step();
    chk("fim_held", {3'd0, bus.pronto, bus.db_estado}, 8'h1C);

    // restart from fim clears jogador
    bus.iniciar = 1'b1;
    step();
    bus.iniciar = 1'b0;
    chk("restart_prep", {4'd0, bus.db_estado}, 8'h01);
    chk("restart_pronto", {7'd0, bus.pronto}, 8'h00);
    step();
    exp_jog = 1'b0;
    chk("restart_st", {4'd0, bus.db_estado}, 8'h02);
    chk("restart_jog", {7'd0, bus.jogador}, {7'd0, exp_jog});

    // reset pulsed in escreve abandons the write immediately
    bus.tem_jogada = 1'b1;
    step();
    bus.tem_jogada = 1'b0;
    step();
    bus.tem_jogada = 1'b1;
    step();
    bus.tem_jogada    = 1'b0;
    bus.jogada_valida = 1'b1;
    step();
    step();
    chk("pre_rst_st", {3'd0, bus.escreve_tabuleiro, bus.db_estado}, 8'h17);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_st", {4'd0, bus.db_estado}, 8'h00);
    chk("async_rst_esc", {7'd0, bus.escreve_tabuleiro}, 8'h00);
    @(posedge clock);
    #1;
    chk("rst_no_write", n_escreve[7:0], exp_escreve[7:0]);
    @(negedge clock);
    reset = 1'b1;
    step();
    chk("post_rst_st", {4'd0, bus.db_estado}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
